line_write_buffer: RTL

//  Posted line write buffer between the data cache's memory port and main_mem. It absorbs

---
 rtl/line_write_buffer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/line_write_buffer.sv
// Posted line write buffer between the data cache and main_mem: absorbs dirty-line
// evictions, drains them in the background and forwards reads that hit buffered lines.
//
// state   | meaning
// U_IDLE  | waiting for a cache read or write request
// U_MEMRD | read miss outstanding at main_mem
// U_GNT   | one-cycle completion pulse to the cache
// D_IDLE  | no write to main_mem in flight
// D_WRITE | head entry being written to main_mem, head entry frozen
module line_write_buffer #(
    parameter int LINE_ADDR_LEN = 2,
    parameter int ADDR_LEN      = 10,
    parameter int DEPTH         = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDR_LEN-1:0]               up_addr,
    input  logic                              up_rd_req,
    input  logic                              up_wr_req,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]  up_wr_line,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]  up_rd_line,
    output logic                              up_gnt,
    output logic [ADDR_LEN-1:0]               mem_addr,
    output logic                              mem_rd_req,
    output logic                              mem_wr_req,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]  mem_wr_line,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]  mem_rd_line,
    input  logic                              mem_gnt
);

    localparam int LINE_W = 32 * (2 ** LINE_ADDR_LEN);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {U_IDLE, U_MEMRD, U_GNT} u_state_t;
    typedef enum logic {D_IDLE, D_WRITE} d_state_t;

    u_state_t u_state, u_next;
    d_state_t d_state, d_next;

    logic [DEPTH-1:0]    ent_valid;
    logic [ADDR_LEN-1:0] ent_addr [DEPTH];
    logic [LINE_W-1:0]   ent_line [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;

    logic             head_hit;
    logic             other_hit;
    logic [PTR_W-1:0] other_idx;
    logic             rd_hit;
    logic [PTR_W-1:0] hit_idx;
    logic             head_busy;
    logic             wr_merge;
    logic             wr_head_stall;
    logic             rd_miss_pending;
    logic             drain_start;
    logic             do_push;
    logic             do_merge;
    logic             rd_fwd;
    logic             rd_issue;
    logic             rd_done;
    logic             do_pop;

    // Split address hits into the head entry and any newer entry; the newer one wins.
    always_comb begin
        head_hit  = 1'b0;
        other_hit = 1'b0;
        other_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == up_addr)) begin
                if (PTR_W'(i) == head) begin
                    head_hit = 1'b1;
                end else begin
                    other_hit = 1'b1;
                    other_idx = PTR_W'(i);
                end
            end
        end
    end

    assign rd_hit          = head_hit || other_hit;
    assign hit_idx         = other_hit ? other_idx : head;
    assign rd_miss_pending = (u_state == U_IDLE) && up_rd_req && !rd_hit;
    assign drain_start     = (d_state == D_IDLE) && (count != '0) &&
                             (u_state != U_MEMRD) && !rd_miss_pending;
    // Head counts as busy on the edge its snapshot is taken, so a merge cannot be lost.
    assign head_busy       = (d_state == D_WRITE) || drain_start;
    assign wr_merge        = other_hit || (head_hit && !head_busy);
    assign wr_head_stall   = head_hit && head_busy && !other_hit;
    assign rd_done         = (u_state == U_MEMRD) && mem_gnt;
    assign do_pop          = (d_state == D_WRITE) && mem_gnt;
    assign up_gnt          = (u_state == U_GNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_state <= U_IDLE;
            d_state <= D_IDLE;
        end else begin
            u_state <= u_next;
            d_state <= d_next;
        end
    end

    always_comb begin
        u_next   = u_state;
        do_push  = 1'b0;
        do_merge = 1'b0;
        rd_fwd   = 1'b0;
        rd_issue = 1'b0;
        case (u_state)
            U_IDLE: begin
                if (up_wr_req) begin
                    if (wr_merge) begin
                        do_merge = 1'b1;
                        u_next   = U_GNT;
                    end else if (!wr_head_stall && (count < CNT_W'(DEPTH))) begin
                        do_push = 1'b1;
                        u_next  = U_GNT;
                    end
                end else if (up_rd_req) begin
                    if (rd_hit) begin
                        rd_fwd = 1'b1;
                        u_next = U_GNT;
                    end else if (d_state == D_IDLE) begin
                        rd_issue = 1'b1;
                        u_next   = U_MEMRD;
                    end
                end
            end
            U_MEMRD: begin
                if (mem_gnt) u_next = U_GNT;
            end
            U_GNT:   u_next = U_IDLE;
            default: u_next = U_IDLE;
        endcase
    end

    always_comb begin
        d_next = d_state;
        case (d_state)
            D_IDLE:  if (drain_start) d_next = D_WRITE;
            D_WRITE: if (mem_gnt) d_next = D_IDLE;
            default: d_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_line[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                ent_valid[tail] <= 1'b1;
                ent_addr[tail]  <= up_addr;
                ent_line[tail]  <= up_wr_line;
                tail            <= tail + PTR_W'(1);
            end
            if (do_merge) begin
                ent_line[hit_idx] <= up_wr_line;
            end
            if (do_pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Read misses and drains never overlap, so one mem_gnt always belongs to one of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr    <= '0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            mem_wr_line <= '0;
            up_rd_line  <= '0;
        end else begin
            if (rd_issue) begin
                mem_rd_req <= 1'b1;
                mem_addr   <= up_addr;
            end else if (rd_done) begin
                mem_rd_req <= 1'b0;
            end
            if (drain_start) begin
                mem_wr_req  <= 1'b1;
                mem_addr    <= ent_addr[head];
                mem_wr_line <= ent_line[head];
            end else if (do_pop) begin
                mem_wr_req <= 1'b0;
            end
            if (rd_fwd) begin
                up_rd_line <= ent_line[hit_idx];
            end else if (rd_done) begin
                up_rd_line <= mem_rd_line;
            end
        end
    end

endmodule
